// File: rtl/sram_bank_ctrl.sv
// Banked SRAM controller: NBANK banks of DW/8 SRAM1RW512x8 macros behind a valid/ready request port.
// Optional macro SRAM_BYTE_WE_EN adds REQ_BE byte-lane write enables; undefined, writes update every lane.

module sram_bank_ctrl #(
   parameter int NBANK = 128,
   parameter int DW    = 8,
   parameter int AW    = 16
) (
   input  logic            CLK,
   input  logic            RSTN,
   input  logic            REQ_VALID,
   output logic            REQ_READY,
   input  logic            REQ_WE,
   input  logic [AW-1:0]   REQ_ADDR,
   input  logic [DW-1:0]   REQ_WDATA,
`ifdef SRAM_BYTE_WE_EN
   input  logic [DW/8-1:0] REQ_BE,
`endif
   output logic            RSP_VALID,
   input  logic            RSP_READY,
   output logic [DW-1:0]   RSP_RDATA,
   output logic            RSP_ERR,
   output logic [7:0]      ERR_CNT
);

   localparam int LANES = DW / 8;
   localparam int BW    = AW - 9;

   typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, RESP} state_t;

   state_t state, state_nx;
   logic   acc_cyc, cap_cyc;

   logic             we_q;
   logic [8:0]       row_q;
   logic [BW-1:0]    bank_q;
   logic [DW-1:0]    wdata_q;
   logic [LANES-1:0] be_q;
   logic             oor_q;

   logic [NBANK-1:0][LANES-1:0] csb;
   logic [NBANK-1:0]            oeb;
   logic                        web;
   logic [NBANK-1:0][DW-1:0]    bank_dout;
   logic [NBANK-1:0][DW-1:0]    bank_gated;
   logic [DW-1:0]               rd_mux;

   always_comb begin
      state_nx  = state;
      REQ_READY = 1'b0;
      RSP_VALID = 1'b0;
      acc_cyc   = 1'b0;
      cap_cyc   = 1'b0;
      case (state)
         IDLE: begin
            REQ_READY = RSTN;
            if (REQ_VALID) state_nx = ACCESS;
         end
         ACCESS: begin
            acc_cyc  = 1'b1;
            state_nx = we_q ? IDLE : CAPTURE;
         end
         CAPTURE: begin
            cap_cyc  = 1'b1;
            state_nx = RESP;
         end
         RESP: begin
            RSP_VALID = 1'b1;
            if (RSP_READY) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RSTN) begin
         state     <= IDLE;
         RSP_RDATA <= '0;
         RSP_ERR   <= 1'b0;
         ERR_CNT   <= '0;
      end else begin
         state <= state_nx;
         if (acc_cyc && oor_q && ERR_CNT != 8'hFF) ERR_CNT <= ERR_CNT + 8'd1;
         if (cap_cyc) begin
            RSP_RDATA <= rd_mux;
            RSP_ERR   <= oor_q;
         end
      end
   end

   // Request fields only matter once the FSM leaves IDLE, so they carry no reset.
   always_ff @(posedge CLK) begin
      if (state == IDLE && REQ_VALID) begin
         we_q    <= REQ_WE;
         row_q   <= REQ_ADDR[8:0];
         bank_q  <= REQ_ADDR[AW-1:9];
         wdata_q <= REQ_WDATA;
         oor_q   <= {1'b0, REQ_ADDR[AW-1:9]} >= (BW+1)'(NBANK);
`ifdef SRAM_BYTE_WE_EN
         be_q    <= REQ_BE;
`else
         be_q    <= '1;
`endif
      end
   end

   assign web = ~(acc_cyc && we_q && RSTN);

   for (genvar b = 0; b < NBANK; b++) begin : g_bank
      logic hit;
      assign hit    = RSTN && !oor_q && (bank_q == BW'(b));
      assign oeb[b] = ~(hit && cap_cyc);
      for (genvar k = 0; k < LANES; k++) begin : g_lane
         assign csb[b][k] = ~(hit && acc_cyc && (!we_q || be_q[k]));
         SRAM1RW512x8 u_mem (
            .CE  (CLK),
            .CSB (csb[b][k]),
            .WEB (web),
            .A   (row_q),
            .I   (wdata_q[8*k +: 8]),
            .O   (bank_dout[b][8*k +: 8])
         );
      end
      assign bank_gated[b] = bank_dout[b] & {DW{~oeb[b]}};
   end

   always_comb begin
      rd_mux = '0;
      for (int unsigned b = 0; b < NBANK; b++) rd_mux = rd_mux | bank_gated[b];
   end

endmodule

// Behavioural 512x8 single-port macro: registered read, write-through disabled.
module SRAM1RW512x8 (
   input  logic       CE,
   input  logic       CSB,
   input  logic       WEB,
   input  logic [8:0] A,
   input  logic [7:0] I,
   output logic [7:0] O
);

   logic [7:0] mem [512];

   always_ff @(posedge CE) begin
      if (!CSB) begin
         if (!WEB) mem[A] <= I;
         else      O      <= mem[A];
      end
   end

endmodule
